// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch in front of decode.
// Holds the fetch PC, issues word requests over a request/grant bus with
// in-order responses, tags each request with its address, and buffers the
// returned words in a 2-entry FIFO presented to decode as valid/ready.
// A redirect reloads the PC, empties the FIFO and marks every response
// still in flight for discard.
module fetch_stage #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  input  logic            id_ready
);

  // Credit limit on requests in flight plus words buffered. The FIFO, tag
  // queue and 1-bit pointers below are sized for exactly two entries.
  localparam logic [2:0] CREDITS = 3'(DEPTH);

  // Fetch address and in-flight bookkeeping.
  logic [PC_W-1:0] pc;
  logic [1:0]      outstanding;
  logic [1:0]      drop;
  logic [1:0]      outstanding_next;

  // Address tags of granted requests, consumed in response order.
  logic [PC_W-1:0] tag_q [2];
  logic            tag_wr;
  logic            tag_rd;

  // Instruction FIFO towards decode.
  logic [31:0]     fifo_inst [2];
  logic [PC_W-1:0] fifo_pc   [2];
  logic            fifo_wr;
  logic            fifo_rd;
  logic [1:0]      count;
  logic [1:0]      count_next;

  // Per-cycle events.
  logic            credit_ok;
  logic            grant;
  logic            resp_ok;
  logic            resp_keep;
  logic            push;
  logic            pop;

  // The two low target bits are ignored: fetches are always word aligned.
  logic            unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Request gating: no request during reset or in a redirect cycle, and only
  // while in-flight plus buffered words leave room in the FIFO.
  always_comb begin
    credit_ok = ({1'b0, outstanding} + {1'b0, count}) < CREDITS;
    imem_req  = rst_n && !redirect && credit_ok;
    imem_addr = pc;
    grant     = imem_req && imem_gnt;
  end

  // Response and FIFO events. A response with nothing outstanding is a bus
  // protocol error and is ignored; a redirect cancels any push or pop.
  always_comb begin
    resp_ok   = imem_rvalid && (outstanding != 2'd0);
    resp_keep = resp_ok && (drop == 2'd0);
    push      = resp_keep && !redirect;
    pop       = inst_valid && id_ready && !redirect;
  end

  // Next in-flight count after this cycle's grant and response.
  always_comb begin
    outstanding_next = outstanding;
    if (grant && !resp_ok) begin
      outstanding_next = outstanding + 2'd1;
    end else if (!grant && resp_ok) begin
      outstanding_next = outstanding - 2'd1;
    end
  end

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
  end

  // Fetch PC: redirect target (word aligned) wins over the post-grant step;
  // the increment wraps naturally at the top of the address space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= {redirect_pc[PC_W-1:2], 2'b00};
    end else if (grant) begin
      pc <= pc + PC_W'(4);
    end
  end

  // In-flight request count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 2'd0;
    end else begin
      outstanding <= outstanding_next;
    end
  end

  // Discard counter: a redirect marks everything still in flight (after this
  // cycle's response) as stale; each stale response then burns one count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 2'd0;
    end else if (redirect) begin
      drop <= outstanding_next;
    end else if (resp_ok && (drop != 2'd0)) begin
      drop <= drop - 2'd1;
    end
  end

  // Tag queue pointers. Not flushed on redirect so tags stay paired with
  // the responses that are being discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr <= 1'b0;
      tag_rd <= 1'b0;
    end else begin
      if (grant) begin
        tag_wr <= ~tag_wr;
      end
      if (resp_ok) begin
        tag_rd <= ~tag_rd;
      end
    end
  end

  // Tag storage: remembers the address of each granted request.
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_q[tag_wr] <= pc;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr <= 1'b0;
      fifo_rd <= 1'b0;
      count   <= 2'd0;
    end else if (redirect) begin
      fifo_wr <= 1'b0;
      fifo_rd <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        fifo_wr <= ~fifo_wr;
      end
      if (pop) begin
        fifo_rd <= ~fifo_rd;
      end
      count <= count_next;
    end
  end

  // FIFO storage: instruction word paired with the tag of its request.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[fifo_wr] <= imem_rdata;
      fifo_pc[fifo_wr]   <= tag_q[tag_rd];
    end
  end

  // Head presentation; data reads as zero whenever the FIFO is empty so no
  // stale word or address is ever shown to decode.
  always_comb begin
    inst_valid = (count != 2'd0);
    inst       = '0;
    inst_pc    = '0;
    if (inst_valid) begin
      inst    = fifo_inst[fifo_rd];
      inst_pc = fifo_pc[fifo_rd];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed vector table after reset, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        id_ready;

  always #5 clk = ~clk;

  fetch_stage #(
    .PC_W    (32),
    .RESET_PC(RPC),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .id_ready   (id_ready)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] inst; logic [31:0] pc; } ent_t;
  typedef struct packed { logic [31:0] addr; logic dropped; } fl_t;

  ent_t        m_fifo[$];   // words decode will see, head first
  fl_t         m_fl[$];     // granted requests awaiting a response
  logic [31:0] m_pc;

  // Memory-side queue of granted addresses with their due cycle.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          mem_lat  = 1;
  int          last_due = -1;

  // Outputs as sampled in the most recent step.
  logic        last_req, last_valid;
  logic [31:0] last_addr, last_pc;

  task automatic model_reset();
    m_fifo.delete();
    m_fl.delete();
    m_pc = RPC;
    mq_addr.delete();
    mq_due.delete();
    last_due = -1;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy,
                      input logic g, input logic spur);
    logic m_req, resp, cons;
    fl_t  f;
    int   due;
    redirect    = redir;
    redirect_pc = rpc;
    id_ready    = rdy;
    imem_gnt    = g;
    resp        = 1'b0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(mq_addr[0]);
      resp        = 1'b1;
    end else if (spur && mq_addr.size() == 0 && m_fl.size() == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    m_req = !redir && ((m_fl.size() + m_fifo.size()) < 2);
    chk("imem_req", imem_req, m_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", inst_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      chk("inst_pc", inst_pc, m_fifo[0].pc);
      chk("inst", inst, m_fifo[0].inst);
    end
    last_req   = imem_req;
    last_addr  = imem_addr;
    last_valid = inst_valid;
    last_pc    = inst_pc;
    // model update
    cons = (m_fifo.size() > 0) && rdy && !redir;
    if (cons) void'(m_fifo.pop_front());
    if (imem_rvalid && m_fl.size() > 0) begin
      f = m_fl.pop_front();
      if (!f.dropped && !redir) m_fifo.push_back('{inst: imem_rdata, pc: f.addr});
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_fl[i]) m_fl[i].dropped = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end else if (m_req && g) begin
      m_fl.push_back('{addr: m_pc, dropped: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    // memory side
    if (resp) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (imem_req && imem_gnt) begin
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      mq_addr.push_back(imem_addr);
      mq_due.push_back(due);
      last_due = due;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset, checked before any clock edge; released at a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst imem_req", imem_req, 1'b0);
    chk("rst imem_addr", imem_addr, RPC);
    chk("rst inst_valid", inst_valid, 1'b0);
    chk("rst inst", inst, 32'h0);
    chk("rst inst_pc", inst_pc, 32'h0);
    model_reset();
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    redirect    = 1'b0;
    id_ready    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tv[7];

  initial begin
    logic [31:0] got[$];
    logic [31:0] grants[$];
    bit          found;

    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b0;
    model_reset();

    // Grant always high, 1-cycle latency, decode always ready.
    tv[0] = '{1'b0, 32'h0,            1'b1, 32'h100, 1'b0, 32'h0};
    tv[1] = '{1'b1, memf(32'h100),    1'b1, 32'h104, 1'b0, 32'h0};
    tv[2] = '{1'b1, memf(32'h104),    1'b0, 32'h108, 1'b1, 32'h100};
    tv[3] = '{1'b0, 32'h0,            1'b1, 32'h108, 1'b1, 32'h104};
    tv[4] = '{1'b1, memf(32'h108),    1'b1, 32'h10C, 1'b0, 32'h0};
    tv[5] = '{1'b1, memf(32'h10C),    1'b0, 32'h110, 1'b1, 32'h108};
    tv[6] = '{1'b0, 32'h0,            1'b1, 32'h110, 1'b1, 32'h10C};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      imem_gnt    = 1'b1;
      id_ready    = 1'b1;
      redirect    = 1'b0;
      imem_rvalid = tv[i].rv;
      imem_rdata  = tv[i].rd;
      #1;
      chk($sformatf("tv%0d imem_req", i), imem_req, tv[i].e_req);
      chk($sformatf("tv%0d imem_addr", i), imem_addr, tv[i].e_addr);
      chk($sformatf("tv%0d inst_valid", i), inst_valid, tv[i].e_val);
      if (tv[i].e_val) begin
        chk($sformatf("tv%0d inst_pc", i), inst_pc, tv[i].e_pc);
        chk($sformatf("tv%0d inst", i), inst, memf(tv[i].e_pc));
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end

    // Mid-stream reset with a request outstanding.
    do_reset();

    // Decode stalls for 12 cycles: FIFO fills, requests stop, head holds.
    mem_lat = 1;
    repeat (12) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("stall imem_req low", last_req, 1'b0);
    chk("stall head pc", last_pc, 32'h100);
    got.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (last_valid) got.push_back(last_pc);
    end
    chk("drain first", got.size() > 0 ? got[0] : 32'hFFFF_FFFF, 32'h100);
    chk("drain second", got.size() > 1 ? got[1] : 32'hFFFF_FFFF, 32'h104);

    // Fill the FIFO again, then reset while it is full.
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("full before reset", last_valid, 1'b1);
    do_reset();

    // Redirect with two fetches outstanding (3-cycle memory).
    mem_lat = 3;
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h2003, 1'b1, 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (last_valid) found = 1;
    end
    chk("redirect valid seen", found, 1'b1);
    chk("redirect first pc", last_pc, 32'h2000);

    // Redirect in the same cycle as a response and a pop.
    do_reset();
    mem_lat = 1;
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h3000, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("flushed after redirect", last_valid, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (last_valid) found = 1;
    end
    chk("post-flush valid seen", found, 1'b1);
    chk("post-flush first pc", last_pc, 32'h3000);

    // PC wrap at the top of memory.
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    grants.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (last_req) grants.push_back(last_addr);
    end
    chk("wrap first addr", grants.size() > 0 ? grants[0] : 32'h1, 32'hFFFF_FFFC);
    chk("wrap second addr", grants.size() > 1 ? grants[1] : 32'h1, 32'h0000_0000);

    // Spurious responses with nothing outstanding are ignored.
    do_reset();
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("spurious no valid", last_valid, 1'b0);
    chk("spurious pc held", last_addr, RPC);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      mem_lat = $urandom_range(1, 4);
      step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
